// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one 4-bit adder/subtractor between two requesters.
// A grant latches the winner's operands; two cycles later the result returns with a one-cycle ack.

module addsub_4bit (
    input  logic       mode_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] s_o,
    output logic       c_out_o
);
    logic [4:0] sum;

    // Subtract is b + ~a + 1, so the carry out doubles as the no-borrow flag.
    assign sum     = {1'b0, b_i} + {1'b0, a_i ^ {4{mode_i}}} + {4'b0000, mode_i};
    assign s_o     = sum[3:0];
    assign c_out_o = sum[4];
endmodule

module addsub_arbiter #(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic       op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res,
    output logic       res_c,
    output logic       busy,
    output logic       gnt_id
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       gnt_id_q, gnt_id_d;
    logic       op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] res_q, res_d;
    logic       res_c_q, res_c_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       winner;
    logic [3:0] dp_s;
    logic       dp_c;

    addsub_4bit u_addsub (
        .mode_i  (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .s_o     (dp_s),
        .c_out_o (dp_c)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        res_c_d    = res_c_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        winner     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner     = (req0 && req1) ? ~last_gnt_q : req1;
                    gnt_id_d   = winner;
                    last_gnt_d = winner;
                    op_d       = winner ? op1 : op0;
                    a_d        = winner ? a1 : a0;
                    b_d        = winner ? b1 : b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_d   = dp_s;
                res_c_d = dp_c;
                ack0_d  = ~gnt_id_q;
                ack1_d  = gnt_id_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= ~PRIORITY_INIT;
            gnt_id_q   <= 1'b0;
            op_q       <= 1'b0;
            a_q        <= 4'h0;
            b_q        <= 4'h0;
            res_q      <= 4'h0;
            res_c_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            res_c_q    <= res_c_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign res    = res_q;
    assign res_c  = res_c_q;
    assign busy   = (state_q != IDLE);
    assign gnt_id = gnt_id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed plan cases plus randomized operations
// compared against an arithmetic / round-robin reference model.

module tb_addsub_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, op0, req1, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1, res_c, busy, gnt_id;
    logic [3:0] res;

    int total  = 0;
    int passed = 0;
    int last_winner;

    addsub_arbiter #(.PRIORITY_INIT(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .res    (res),
        .res_c  (res_c),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference arithmetic: add = full 5-bit b + a; subtract = (b - a) mod 16 with no-borrow flag.
    function automatic logic [4:0] ref_calc(input logic op, input logic [3:0] a, input logic [3:0] b);
        int r;
        if (!op) begin
            r = int'(b) + int'(a);
            return 5'(r);
        end
        r = int'(b) - int'(a);
        return {(int'(b) >= int'(a)), 4'(r + 16)};
    endfunction

    // Wait (bounded) for an ack; check its timing, owner and result, then drop that request.
    task automatic wait_ack(input int exp_id, input int exp_lat, input logic [4:0] exp_val, input string tag);
        int  n   = 0;
        bit  got = 0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) got = 1;
        end
        check({tag, "_ack_seen"}, 8'(got), 8'd1);
        check({tag, "_latency"}, 8'(n), 8'(exp_lat));
        check({tag, "_ack0"}, 8'(ack0), 8'(exp_id == 0));
        check({tag, "_ack1"}, 8'(ack1), 8'(exp_id == 1));
        check({tag, "_res"}, 8'(res), 8'(exp_val[3:0]));
        check({tag, "_res_c"}, 8'(res_c), 8'(exp_val[4]));
        check({tag, "_gnt_id"}, 8'(gnt_id), 8'(exp_id));
        check({tag, "_busy"}, 8'(busy), 8'd1);
        if (!got) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end else if (exp_id == 0) begin
            req0 = 1'b0;
        end else begin
            req1 = 1'b0;
        end
    endtask

    task automatic drive(input int id, input logic op, input logic [3:0] a, input logic [3:0] b);
        if (id == 0) begin
            op0 = op; a0 = a; b0 = b; req0 = 1'b1;
        end else begin
            op1 = op; a1 = a; b1 = b; req1 = 1'b1;
        end
    endtask

    task automatic single(input int id, input logic op, input logic [3:0] a, input logic [3:0] b, input string tag);
        @(negedge clk);
        drive(id, op, a, b);
        wait_ack(id, 2, ref_calc(op, a, b), tag);
        last_winner = id;
    endtask

    // Both requesters raised together: the one not granted last wins, the other follows 3 cycles later.
    task automatic pair(input string tag);
        logic       p0, p1;
        logic [3:0] x0, y0, x1, y1;
        int         w;
        p0 = 1'($urandom); x0 = 4'($urandom); y0 = 4'($urandom);
        p1 = 1'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
        w  = 1 - last_winner;
        @(negedge clk);
        drive(0, p0, x0, y0);
        drive(1, p1, x1, y1);
        if (w == 0) begin
            wait_ack(0, 2, ref_calc(p0, x0, y0), {tag, "_first"});
            wait_ack(1, 3, ref_calc(p1, x1, y1), {tag, "_second"});
        end else begin
            wait_ack(1, 2, ref_calc(p1, x1, y1), {tag, "_first"});
            wait_ack(0, 3, ref_calc(p0, x0, y0), {tag, "_second"});
        end
        last_winner = 1 - w;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, 8'(ack0), 8'd0);
        check({tag, "_ack1"}, 8'(ack1), 8'd0);
        check({tag, "_busy"}, 8'(busy), 8'd0);
        check({tag, "_res"}, 8'(res), 8'd0);
        check({tag, "_res_c"}, 8'(res_c), 8'd0);
        check({tag, "_gnt_id"}, 8'(gnt_id), 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_winner = 1;  // PRIORITY_INIT = 0 wins the first tie
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; op0 = 1'b0; a0 = 4'h0; b0 = 4'h0;
        req1 = 1'b0; op1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
        last_winner = 1;

        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // Directed arithmetic cases
        single(0, 1'b0, 4'h3, 4'h5, "add_5p3");
        check("add_5p3_value", 8'(res), 8'h8);
        single(1, 1'b1, 4'h3, 4'h5, "sub_5m3");
        check("sub_5m3_value", 8'({res_c, res}), 8'h12);
        single(1, 1'b1, 4'h5, 4'h3, "sub_3m5");
        check("sub_3m5_value", 8'({res_c, res}), 8'h0E);
        single(0, 1'b0, 4'h9, 4'h8, "add_8p9");
        check("add_8p9_value", 8'({res_c, res}), 8'h11);
        single(0, 1'b1, 4'hF, 4'hF, "sub_FmF");
        check("sub_FmF_value", 8'({res_c, res}), 8'h10);

        // Result holds between acks
        @(negedge clk);
        check("hold_res", 8'(res), 8'h0);
        check("hold_res_c", 8'(res_c), 8'h1);

        // Tie-breaking after reset and round-robin alternation over 8 operations
        do_reset();
        for (int i = 0; i < 4; i++) pair($sformatf("rr%0d", i));

        // Operands changed during EXEC must not affect the result
        @(negedge clk);
        drive(0, 1'b0, 4'h2, 4'h4);
        @(negedge clk);
        check("late_op_busy", 8'(busy), 8'd1);
        a0 = 4'hD; b0 = 4'hA; op0 = 1'b1;
        wait_ack(0, 1, ref_calc(1'b0, 4'h2, 4'h4), "late_op");
        last_winner = 0;

        // Reset during EXEC abandons the operation
        @(negedge clk);
        drive(0, 1'b0, 4'h7, 4'h6);
        @(negedge clk);
        check("mid_rst_busy_before", 8'(busy), 8'd1);
        rst_n = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        last_winner = 1;
        @(negedge clk);
        check("mid_rst_no_ack0", 8'(ack0), 8'd0);
        single(1, 1'b0, 4'h4, 4'hB, "post_rst");

        // Randomized single-requester operations
        for (int i = 0; i < 10; i++) begin
            single(int'($urandom_range(1, 0)), 1'($urandom), 4'($urandom), 4'($urandom),
                   $sformatf("rand%0d", i));
        end

        // Randomized ties, continuing the round-robin history
        for (int i = 0; i < 3; i++) pair($sformatf("rtie%0d", i));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
